imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 START  in  1  one-cycle pulse that begins a load.
REQ-006 RX_VALID  in  1  byte-stream valid.
REQ-007 RX_DATA  in  8  byte-stream data.
REQ-008 RX_READY  out  1  byte accepted on a cycle with RX_VALID && RX_READY.
REQ-009 IMEM_WE  out  1  instruction-memory write strobe, one cycle per word.
REQ-010 IMEM_ADDR  out  32  word-aligned byte address of the write.
REQ-011 IMEM_WDATA  out  32  word to write.
REQ-012 CPU_RESET  out  1  active-high reset to the core; held while loading.
REQ-013 DONE  out  1  image loaded; core released.
REQ-014 ERR  out  1  load aborted; core held in reset.

Function
REQ-015 FSM states: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
REQ-016 IDLE: RX_READY=0, CPU_RESET=1; START -> LEN. RX_VALID is ignored.
REQ-017 RX_READY=1 only in LEN, DATA, CSUM.
REQ-018 Words are big-endian. The first accepted byte of each group of 4 goes to bits [31:24]. A 2-bit byte counter wraps 3->0.
REQ-019 LEN: 4 bytes form word count N. N==0 -> DONE (CSUM if enabled). N>DEPTH -> ERR. Otherwise -> DATA.
REQ-020 DATA: after the 4th byte, next state is WRITE.
REQ-021 WRITE lasts exactly 1 cycle: IMEM_WE=1, RX_READY=0, IMEM_ADDR=BASE_ADDR+4*idx, IMEM_WDATA=assembled word.
REQ-022 Word index idx starts at 0 and increments after each WRITE.
REQ-023 After WRITE: idx==N -> DONE (CSUM if enabled); else -> DATA.
REQ-024 Write latency: IMEM_WE rises the cycle after the 4th byte of a word is accepted.
REQ-025 DONE: DONE=1, CPU_RESET=0, RX_READY=0.
REQ-026 ERR: ERR=1, CPU_RESET=1, RX_READY=0.
REQ-027 START in DONE or ERR clears DONE/ERR, sets CPU_RESET=1, and enters LEN (reload).
REQ-028 START in LEN, DATA, WRITE or CSUM is ignored.
REQ-029 Outside WRITE: IMEM_WE=0; IMEM_ADDR and IMEM_WDATA hold their last values.
REQ-030 Stalls on RX_VALID=0 are unbounded, with no timeout.

Reset
REQ-031 RESET_N low asynchronously forces state IDLE, byte counter 0, idx 0, IMEM_WE=0, IMEM_ADDR=BASE_ADDR, IMEM_WDATA=0, RX_READY=0, CPU_RESET=1, DONE=0, ERR=0.
REQ-032 Reset mid-load discards partial words. Already-written memory words are not restored.

Configuration
REQ-033 With macro IMEM_LOADER_CHECKSUM_EN defined, the module keeps a running 32-bit sum (mod 2^32) of all written words. CSUM accepts 4 more bytes; equal to the sum -> DONE, else -> ERR.
REQ-034 Without the macro, the CSUM state and sum register are absent, and completion goes directly to DONE.

Structure
REQ-035 Package imem_loader_pkg holds the FSM state enum, a BYTES_PER_WORD=4 constant, and the default DEPTH and BASE_ADDR.
REQ-036 One sub-module, byte_packer, holds the byte counter and shift register and emits a word-valid pulse.
REQ-037 The FSM, index counter and write port live in imem_loader.

Verification
REQ-038 Load START, bytes 00 00 00 02, 20 08 00 05, 01 09 50 20 -> two WE pulses: addr 0x0 data 0x20080005, then addr 0x4 data 0x01095020; DONE=1, CPU_RESET=0.
REQ-039 Header 00 00 01 01 with DEPTH=256 -> ERR=1, no WE, CPU_RESET stays 1.
REQ-040 Header 00 00 00 00 -> DONE without any WE (checksum 00 00 00 00 required if enabled).
REQ-041 RX_VALID toggling every other cycle during REQ-038 -> identical writes, and RX_READY=0 in each WRITE cycle.
REQ-042 RESET_N low after 6 bytes, then START and a full image -> first WE at addr 0x0 with the new word.
REQ-043 With IMEM_LOADER_CHECKSUM_EN, image of REQ-038 plus trailer 21 11 50 25 -> DONE; plus trailer 00 00 00 00 -> ERR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CSUM = 3'd4
`endif
  } state_e;

  localparam int          BYTES_PER_WORD    = 4;
  localparam int          DEFAULT_DEPTH     = 256;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // States in which the loader pulls bytes from the stream.
  function automatic logic accepts_bytes(input state_e s);
    logic acc;
    case (s)
      ST_LEN, ST_DATA: acc = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM:         acc = 1'b1;
`endif
      default:         acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of each group lands in [31:23+1].
// word_valid pulses combinationally with the 4th accepted byte so the FSM can act on that edge.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_r;
  logic [23:0]      shift_r;

  // Byte counter (wraps naturally) and the three leading bytes of the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      shift_r <= 24'h00_0000;
    end else if (clear) begin
      cnt_r   <= '0;
      shift_r <= 24'h00_0000;
    end else if (byte_en) begin
      cnt_r   <= cnt_r + CNT_W'(1);
      shift_r <= {shift_r[15:0], byte_data};
    end else begin
      cnt_r   <= cnt_r;
      shift_r <= shift_r;
    end
  end

  assign word_valid = byte_en && (cnt_r == CNT_W'(BYTES_PER_WORD - 1));
  assign word       = {shift_r, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed image into instruction memory while holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum of all written words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CSUM;
  logic [31:0] sum_r;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  state_e      state_r, state_s;
  logic [31:0] n_words_r, idx_r, word_s;
  logic [31:0] imem_addr_r, imem_wdata_r;
  logic        word_valid_s, byte_en_s, load_start_s;
  logic        rx_ready_r, imem_we_r, cpu_reset_r, done_r, err_r;

  assign byte_en_s    = rx_valid && rx_ready_r;
  assign load_start_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (load_start_s),
    .byte_en    (byte_en_s),
    .byte_data  (rx_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LEN;
        else       state_s = ST_IDLE;
      end
      ST_LEN: begin
        if (!word_valid_s)                 state_s = ST_LEN;
        else if (word_s == 32'd0)          state_s = ST_TAIL;
        else if (word_s > 32'(DEPTH))      state_s = ST_ERR;
        else                               state_s = ST_DATA;
      end
      ST_DATA: begin
        if (word_valid_s) state_s = ST_WRITE;
        else              state_s = ST_DATA;
      end
      ST_WRITE: begin
        if (idx_r + 32'd1 == n_words_r) state_s = ST_TAIL;
        else                            state_s = ST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (!word_valid_s)        state_s = ST_CSUM;
        else if (word_s == sum_r) state_s = ST_DONE;
        else                      state_s = ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (start) state_s = ST_LEN;
        else       state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Index/length tracking, write port and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r        <= 32'd0;
      n_words_r    <= 32'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= BASE_ADDR;
      imem_wdata_r <= 32'd0;
      rx_ready_r   <= 1'b0;
      cpu_reset_r  <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_r        <= 32'd0;
`endif
    end else begin
      imem_we_r   <= (state_s == ST_WRITE);
      rx_ready_r  <= accepts_bytes(state_s);
      cpu_reset_r <= (state_s != ST_DONE);
      done_r      <= (state_s == ST_DONE);
      err_r       <= (state_s == ST_ERR);
      if (load_start_s) begin
        idx_r <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_r <= 32'd0;
`endif
      end
      if ((state_r == ST_LEN) && word_valid_s) n_words_r <= word_s;
      // Address and data are captured with the last byte and held until the next word.
      if ((state_r == ST_DATA) && word_valid_s) begin
        imem_addr_r  <= BASE_ADDR + {idx_r[29:0], 2'b00};
        imem_wdata_r <= word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_r        <= sum_r + word_s;
`endif
      end
      if (state_r == ST_WRITE) idx_r <= idx_r + 32'd1;
    end
  end

  assign rx_ready   = rx_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a queue-based image model.
// Honours IMEM_LOADER_CHECKSUM_EN when compiled with the same define as the RTL.
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_reset, done, err;
  logic [31:0] imem_addr, imem_wdata;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  img_q[$];
  bit          exp_done, exp_err;
  bit          tog = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Every write strobe must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("we_addr", imem_addr, e[63:32]);
        chk("we_data", imem_wdata, e[31:0]);
      end
      chk("ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  function automatic logic [31:0] img_word(input int at);
    return {img_q[at], img_q[at+1], img_q[at+2], img_q[at+3]};
  endfunction

  // Reference: parse the image by its rules; returns bytes the loader will consume.
  task automatic model(output int used);
    logic [31:0] n, w, s;
    s = 32'd0;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = img_word(0);
    used = 4;
    if (n > 32'(DEPTH)) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = img_word(used);
        used += 4;
        exp_q.push_back({BASE + 32'(4 * i), w});
        s += w;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (img_word(used) == s) exp_done = 1'b1;
      else                     exp_err  = 1'b1;
      used += 4;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) img_q.push_back(w[8*k +: 8]);
  endtask

  task automatic make_image(input logic [31:0] n, input bit good_ck);
    logic [31:0] w, s;
    s = 32'd0;
    img_q.delete();
    push_word(n);
    if (n <= 32'(DEPTH)) begin
      for (int i = 0; i < int'(n); i++) begin
        w = $urandom;
        push_word(w);
        s += w;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!good_ck) s = s ^ (32'd1 << $urandom_range(31));
      push_word(s);
`else
      if (!good_ck) s = 32'd0;
`endif
    end
  endtask

  // mode 0: continuous valid, 1: valid toggles each cycle, 2: random gaps and stray starts.
  task automatic send_byte(input logic [7:0] b, input int mode, input bit allow_start);
    bit sent = 1'b0;
    bit gap;
    int guard = 0;
    while (!sent && guard < 2000) begin
      @(negedge clk);
      guard++;
      start = allow_start && ($urandom_range(19) == 0);
      if (mode == 1)      gap = tog;
      else if (mode == 2) gap = ($urandom_range(99) < 30);
      else                gap = 1'b0;
      tog = ~tog;
      if (gap) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        sent     = rx_ready;
      end
    end
    if (!sent) chk("rx_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_image(input int mode, input string tag);
    int used;
    model(used);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    for (int i = 0; i < used; i++) send_byte(img_q[i], mode, (mode == 2) && (i > 0));
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    for (int k = 0; k < 20 && !(done || err); k++) @(negedge clk);
    chk({tag, "_done"},      {31'd0, done},      {31'd0, exp_done});
    chk({tag, "_err"},       {31'd0, err},       {31'd0, exp_err});
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~exp_done});
    chk({tag, "_ready"},     {31'd0, rx_ready},  32'd0);
    chk({tag, "_we_idle"},   {31'd0, imem_we},   32'd0);
    chk({tag, "_pending"},   32'(exp_q.size()),  32'd0);
  endtask

  task automatic load_example();
    img_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] n;
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, rx_ready},  32'd0);
    chk("rst_cpu",   {31'd0, cpu_reset}, 32'd1);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_err",   {31'd0, err},       32'd0);
    chk("rst_we",    {31'd0, imem_we},   32'd0);
    chk("rst_addr",  imem_addr,          BASE);
    chk("rst_wdata", imem_wdata,         32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, rx_ready}, 32'd0);

    load_example();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'h2111_5025);
`endif
    run_image(0, "example");
    load_example();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'h2111_5025);
`endif
    run_image(1, "toggle");

    img_q = '{8'h00, 8'h00, 8'h01, 8'h01};
    run_image(0, "too_long");
    img_q.delete();
    push_word(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'd0);
`endif
    run_image(0, "empty");
`ifdef IMEM_LOADER_CHECKSUM_EN
    load_example();
    push_word(32'd0);
    run_image(0, "bad_csum");
`endif

    // Reset part-way through a load, then a fresh image must start at word 0.
    load_example();
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(img_q[i], 0, 1'b0);
    @(negedge clk);
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("midrst_cpu",   {31'd0, cpu_reset}, 32'd1);
    chk("midrst_ready", {31'd0, rx_ready},  32'd0);
    reset_n = 1'b1;
    img_q.delete();
    push_word(32'd1);
    push_word(32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'hDEAD_BEEF);
`endif
    run_image(0, "after_rst");

    make_image(32'(DEPTH), 1'b1);
    run_image(0, "full_depth");
    make_image(32'hFFFF_FFFF, 1'b1);
    run_image(0, "huge_len");

    for (int t = 0; t < 15; t++) begin
      int r;
      r = $urandom_range(9);
      if (r == 0)      n = 32'd0;
      else if (r == 1) n = 32'(DEPTH) + 32'd1 + 32'($urandom_range(5000));
      else             n = 32'($urandom_range(6, 1));
      make_image(n, $urandom_range(3) != 0);
      run_image(2, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
